bus_io_ctrl: RTL and testbench
==============================

# bus_io_ctrl

Bus-side slave for the single-cycle CPU: decodes the CPU's address/control/data bus, serves a 256-word data RAM and a small memory-mapped I/O window, and returns read data plus read/write-ready flags. The ready flags drive the CPU's stall. When a flag is low for an I/O access, the CPU holds its PC and suppresses its register write until the flag rises. I/O uses an input FIFO fed by a valid/ready producer and an output FIFO drained by a valid/ready consumer.

## Interface
- IN_DEPTH, 4, input FIFO entries (power of two, ≥2)
- OUT_DEPTH, 2, output FIFO entries (power of two, ≥2)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- a_bus  in  32  CPU byte address (ALU result)
- d_bus_2  in  32  CPU write data
- c_bus  in  2  {mem_write, mem_read} from CPU
- d_bus_1  out  34  {wr_rdy, rd_rdy, rdata[31:0]} to CPU
- in_data  in  32  producer data
- in_valid  in  1  producer has data
- in_ready  out  1  input FIFO can accept
- out_data  out  32  head of output FIFO
- out_valid  out  1  output FIFO non-empty
- out_ready  in  1  consumer accepts out_data

## Operation
- Decode (io = a_bus > 32'h400, matching the CPU stall rule):
  - !io: RAM, word index a_bus[9:2]; 0x400 aliases RAM word 0.
  - 0x404 IN_DATA: pops the input FIFO on read.
  - 0x408 OUT_DATA: pushes the output FIFO on write.
  - 0x40C STATUS: read-only, value {30'b0, out_full, in_nonempty}.
  - Any other io address is unmapped: reads return 0, writes are dropped.
- rdata (combinational from a_bus):
  - RAM word.
  - Input FIFO head, or 0 when the FIFO is empty.
  - STATUS value.
  - 0 for unmapped addresses.
- rd_rdy: 0 only when a_bus==0x404 and the input FIFO is empty; 1 otherwise.
- wr_rdy: 0 only when a_bus==0x408 and the output FIFO is full; 1 otherwise.
- The ready flags depend on a_bus and FIFO state only, never on c_bus.
- RAM write: on posedge, when c_bus[1] & !io, RAM[a_bus[9:2]] <= d_bus_2. The RAM has no reset; contents survive rst.
- Input FIFO:
  - push: in_valid & in_ready.
  - pop: c_bus[0] & a_bus==0x404 & nonempty.
  - in_ready = !full & !rst. It does not look ahead to a same-cycle pop.
  - Simultaneous push and pop (FIFO neither empty nor full) keeps the count unchanged and preserves order.
- Output FIFO:
  - push: c_bus[1] & a_bus==0x408 & !full.
  - pop: out_valid & out_ready.
  - Simultaneous push and pop keeps the count unchanged.
  - A write to 0x408 while full is not performed; the CPU stalls and re-presents it every cycle until a pop frees a slot.
- Pointers have log2(depth)+1 bits and wrap modulo 2·depth.
  - empty: pointers equal.
  - full: MSBs differ and the low bits are equal.
- The CPU drives c_bus continuously during a stall. The block performs each access once, in the first cycle its ready flag is 1.

## Timing
- Reset (async), applied immediately:
  - both FIFOs empty, pointers 0
  - out_valid=0, in_ready=0 while rst is high, then 1
  - rd_rdy=1 and wr_rdy=1 unless a_bus selects an empty/full FIFO
- Reads are zero-latency combinational: rdata and the ready flags are valid in the same cycle as a_bus.
- Writes and pops take effect at the rising edge; the new state is visible on the outputs in the next cycle.
- Input: data pushed at edge N can be read by the CPU at 0x404 in cycle N+1.
  - Stall length = cycles until the push edge plus 0.
- Output: a CPU write at edge N gives out_valid=1 and out_data=d_bus_2 in cycle N+1.
- Reset asserted mid-stall clears both FIFOs. The CPU's PC also resets, so no access is replayed.

## Test plan
- RAM: write 0xDEADBEEF to 0x010 (c_bus=2'b10); next cycle read 0x010 (c_bus=2'b01) -> rdata=0xDEADBEEF, d_bus_1[33:32]=2'b11. Read 0x400 -> RAM word 0.
- Input stall: FIFO empty, CPU reads 0x404 -> rd_rdy=0 for 3 cycles. Producer pushes 0x12 at edge 3 -> cycle 4: rd_rdy=1, rdata=0x12. After the pop edge, FIFO empty and STATUS=0.
- Input full: push 4 words (1,2,3,4) with no CPU reads -> in_ready=0. Then read 0x404 with in_valid held -> pops 1. in_ready stays 0 during that cycle, rises the next, fifth word accepted. Order 1,2,3,4,5 preserved.
- Output backpressure: out_ready=0, CPU writes 0xA then 0xB to 0x408, then writes 0xC -> wr_rdy=0 and STATUS[1]=1. Raise out_ready for one cycle -> 0xA consumed. Next cycle wr_rdy=1, 0xC is pushed, and no duplicate 0xC appears.
- Unmapped/status: read 0x500 -> rdata=0, rd_rdy=1. Write 0x500 -> no FIFO or RAM change.
- Async reset: rst pulse mid-cycle with both FIFOs holding data -> out_valid=0 and in_ready=0 immediately. After release, in_ready=1, STATUS=0, and RAM contents are unchanged.

Source files
------------

// File: rtl/bus_io_ctrl.sv
// bus_io_ctrl: CPU bus slave with a 256-word data RAM and a memory-mapped
// I/O window.
// The window holds an input FIFO (0x404), an output FIFO (0x408) and a
// STATUS word (0x40C).
// Ports:
//   clk, rst          clock, async active-high reset
//   a_bus, d_bus_2    CPU address and write data
//   c_bus             {mem_write, mem_read}
//   d_bus_1           {wr_rdy, rd_rdy, rdata}; the ready flags stall the CPU
//   in_*              valid/ready producer feeding the input FIFO
//   out_*             valid/ready consumer draining the output FIFO
module bus_io_ctrl #(
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a_bus,
    input  logic [31:0] d_bus_2,
    input  logic [1:0]  c_bus,
    output logic [33:0] d_bus_1,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int IAW = $clog2(IN_DEPTH);
    localparam int OAW = $clog2(OUT_DEPTH);

    localparam logic [31:0] A_IO   = 32'h0000_0400;
    localparam logic [31:0] A_IN   = 32'h0000_0404;
    localparam logic [31:0] A_OUT  = 32'h0000_0408;
    localparam logic [31:0] A_STAT = 32'h0000_040C;

    logic [31:0] r_ram [256];

    logic [IAW:0]  r_in_wp;
    logic [IAW:0]  r_in_rp;
    logic [31:0]   r_in_mem [IN_DEPTH];
    logic [OAW:0]  r_out_wp;
    logic [OAW:0]  r_out_rp;
    logic [31:0]   r_out_mem [OUT_DEPTH];

    logic        w_io;
    logic        w_sel_in;
    logic        w_sel_out;
    logic        w_sel_stat;
    logic        w_in_empty;
    logic        w_in_full;
    logic        w_out_empty;
    logic        w_out_full;
    logic        w_in_push;
    logic        w_in_pop;
    logic        w_out_push;
    logic        w_out_pop;
    logic        w_rd_rdy;
    logic        w_wr_rdy;
    logic [31:0] w_rdata;

    // 0x400 itself is still RAM (aliases word 0); only strictly above is I/O.
    assign w_io       = a_bus > A_IO;
    assign w_sel_in   = a_bus == A_IN;
    assign w_sel_out  = a_bus == A_OUT;
    assign w_sel_stat = a_bus == A_STAT;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign w_in_empty  = r_in_wp == r_in_rp;
    assign w_in_full   = (r_in_wp[IAW] != r_in_rp[IAW]) &&
                         (r_in_wp[IAW-1:0] == r_in_rp[IAW-1:0]);
    assign w_out_empty = r_out_wp == r_out_rp;
    assign w_out_full  = (r_out_wp[OAW] != r_out_rp[OAW]) &&
                         (r_out_wp[OAW-1:0] == r_out_rp[OAW-1:0]);

    // in_ready deliberately ignores a same-cycle pop to keep it off the
    // CPU address path.
    assign in_ready   = !w_in_full && !rst;
    assign w_in_push  = in_valid && in_ready;
    assign w_in_pop   = c_bus[0] && w_sel_in && !w_in_empty;
    assign w_out_push = c_bus[1] && w_sel_out && !w_out_full;
    assign w_out_pop  = !w_out_empty && out_ready;

    // Ready flags depend only on address and FIFO state so a stalled CPU
    // sees them settle without a loop through c_bus.
    assign w_rd_rdy = !(w_sel_in && w_in_empty);
    assign w_wr_rdy = !(w_sel_out && w_out_full);

    always_comb begin
        w_rdata = '0;
        if (!w_io) begin
            w_rdata = r_ram[a_bus[9:2]];
        end else if (w_sel_in) begin
            w_rdata = w_in_empty ? '0 : r_in_mem[r_in_rp[IAW-1:0]];
        end else if (w_sel_stat) begin
            w_rdata = {30'b0, w_out_full, !w_in_empty};
        end
    end

    assign d_bus_1   = {w_wr_rdy, w_rd_rdy, w_rdata};
    assign out_valid = !w_out_empty;
    assign out_data  = r_out_mem[r_out_rp[OAW-1:0]];

    // RAM has no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (c_bus[1] && !w_io) begin
            r_ram[a_bus[9:2]] <= d_bus_2;
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_push) begin
            r_in_mem[r_in_wp[IAW-1:0]] <= in_data;
        end
        if (w_out_push) begin
            r_out_mem[r_out_wp[OAW-1:0]] <= d_bus_2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_wp  <= '0;
            r_in_rp  <= '0;
            r_out_wp <= '0;
            r_out_rp <= '0;
        end else begin
            r_in_wp  <= r_in_wp  + {{IAW{1'b0}}, w_in_push};
            r_in_rp  <= r_in_rp  + {{IAW{1'b0}}, w_in_pop};
            r_out_wp <= r_out_wp + {{OAW{1'b0}}, w_out_push};
            r_out_rp <= r_out_rp + {{OAW{1'b0}}, w_out_pop};
        end
    end

endmodule

// File: tb/tb_bus_io_ctrl.sv
// tb_bus_io_ctrl: directed and randomized bench for bus_io_ctrl, compared
// against a queue/array reference model.
module tb_bus_io_ctrl;

    localparam int IN_D  = 4;
    localparam int OUT_D = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_bus;
    logic [31:0] d_bus_2;
    logic [1:0]  c_bus;
    logic [33:0] d_bus_1;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int errs   = 0;
    int checks = 0;

    logic [31:0] m_ram [256];
    logic [31:0] m_in  [$];
    logic [31:0] m_out [$];

    bus_io_ctrl #(.IN_DEPTH(IN_D), .OUT_DEPTH(OUT_D)) dut (
        .clk(clk), .rst(rst),
        .a_bus(a_bus), .d_bus_2(d_bus_2), .c_bus(c_bus),
        .d_bus_1(d_bus_1),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Settle, then compare every output with the model's view.
    task automatic look();
        logic [31:0] e_rd;
        logic        io;
        #2;
        io   = a_bus > 32'h400;
        e_rd = 32'h0;
        if (!io)
            e_rd = m_ram[a_bus[9:2]];
        else if (a_bus == 32'h404)
            e_rd = (m_in.size() > 0) ? m_in[0] : 32'h0;
        else if (a_bus == 32'h40C)
            e_rd = {30'b0, m_out.size() == OUT_D, m_in.size() != 0};
        chk("rdata", d_bus_1[31:0], e_rd);
        chk("rd_rdy", {31'b0, d_bus_1[32]},
            {31'b0, !(a_bus == 32'h404 && m_in.size() == 0)});
        chk("wr_rdy", {31'b0, d_bus_1[33]},
            {31'b0, !(a_bus == 32'h408 && m_out.size() == OUT_D)});
        chk("in_ready", {31'b0, in_ready}, {31'b0, m_in.size() < IN_D});
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_out.size() > 0});
        if (m_out.size() > 0)
            chk("out_data", out_data, m_out[0]);
    endtask

    // Apply this cycle's effects to the model, then cross the edge.
    task automatic adv();
        bit push_i, pop_i, push_o, pop_o, ram_w;
        push_i = in_valid && (m_in.size() < IN_D);
        pop_i  = c_bus[0] && a_bus == 32'h404 && m_in.size() > 0;
        push_o = c_bus[1] && a_bus == 32'h408 && m_out.size() < OUT_D;
        pop_o  = out_ready && m_out.size() > 0;
        ram_w  = c_bus[1] && a_bus <= 32'h400;
        if (pop_i)  void'(m_in.pop_front());
        if (push_i) m_in.push_back(in_data);
        if (pop_o)  void'(m_out.pop_front());
        if (push_o) m_out.push_back(d_bus_2);
        if (ram_w)  m_ram[a_bus[9:2]] = d_bus_2;
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [31:0] a, input logic [1:0] c,
                       input logic [31:0] d);
        a_bus   = a;
        c_bus   = c;
        d_bus_2 = d;
    endtask

    initial begin
        rst = 1'b1;
        bus(32'h404, 2'b00, 32'h0);
        in_data = 0; in_valid = 0; out_ready = 0;
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
        chk("rst_rd_rdy", {31'b0, d_bus_1[32]}, 32'h0);
        chk("rst_wr_rdy", {31'b0, d_bus_1[33]}, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Preload every RAM word so the model knows all contents.
        for (int i = 0; i < 256; i++) begin
            bus(i * 4, 2'b10, $urandom);
            look(); adv();
        end

        // RAM write/read and 0x400 alias.
        bus(32'h010, 2'b10, 32'hDEADBEEF);
        look(); adv();
        bus(32'h010, 2'b01, 32'h0);
        look();
        chk("ram_rd", d_bus_1[31:0], 32'hDEADBEEF);
        chk("ram_rdy", {30'b0, d_bus_1[33:32]}, 32'h3);
        adv();
        bus(32'h400, 2'b01, 32'h0);
        look();
        chk("alias0", d_bus_1[31:0], m_ram[0]);
        adv();

        // Input stall: producer arrives at the third edge.
        bus(32'h404, 2'b01, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) begin in_valid = 1; in_data = 32'h12; end
            look();
            chk("stall_rd_rdy", {31'b0, d_bus_1[32]}, 32'h0);
            adv();
        end
        in_valid = 0;
        look();
        chk("stall_rel_rdy", {31'b0, d_bus_1[32]}, 32'h1);
        chk("stall_rel_data", d_bus_1[31:0], 32'h12);
        adv();
        bus(32'h40C, 2'b01, 32'h0);
        look();
        chk("stat_empty", d_bus_1[31:0], 32'h0);
        adv();

        // Input full, then a pop frees room for a fifth word.
        bus(32'h500, 2'b00, 32'h0);
        in_valid = 1;
        for (int i = 1; i <= 4; i++) begin
            in_data = i;
            look(); adv();
        end
        in_data = 5;
        bus(32'h404, 2'b01, 32'h0);
        look();
        chk("full_in_ready", {31'b0, in_ready}, 32'h0);
        chk("full_head", d_bus_1[31:0], 32'h1);
        adv();
        bus(32'h500, 2'b00, 32'h0);
        look();
        chk("refill_in_ready", {31'b0, in_ready}, 32'h1);
        adv();
        in_valid = 0;
        for (int v = 2; v <= 5; v++) begin
            bus(32'h404, 2'b01, 32'h0);
            look();
            chk("order", d_bus_1[31:0], v);
            adv();
        end

        // Output backpressure.
        out_ready = 0;
        bus(32'h408, 2'b10, 32'hA); look(); adv();
        bus(32'h408, 2'b10, 32'hB); look(); adv();
        bus(32'h40C, 2'b01, 32'h0);
        look();
        chk("stat_out_full", {31'b0, d_bus_1[1]}, 32'h1);
        adv();
        bus(32'h408, 2'b10, 32'hC);
        look();
        chk("bp_wr_rdy0", {31'b0, d_bus_1[33]}, 32'h0);
        adv();
        out_ready = 1;
        look();
        chk("bp_wr_rdy_pop", {31'b0, d_bus_1[33]}, 32'h0);
        chk("bp_head_a", out_data, 32'hA);
        adv();
        out_ready = 0;
        look();
        chk("bp_wr_rdy1", {31'b0, d_bus_1[33]}, 32'h1);
        adv();
        bus(32'h500, 2'b00, 32'h0);
        out_ready = 1;
        look();
        chk("bp_head_b", out_data, 32'hB);
        adv();
        look();
        chk("bp_head_c", out_data, 32'hC);
        adv();
        out_ready = 0;
        look();
        chk("bp_no_dup", {31'b0, out_valid}, 32'h0);
        adv();

        // Unmapped read/write.
        bus(32'h500, 2'b01, 32'h0);
        look();
        chk("unmap_rd", d_bus_1[31:0], 32'h0);
        chk("unmap_rdy", {31'b0, d_bus_1[32]}, 32'h1);
        adv();
        bus(32'h500, 2'b10, 32'hFFFF_FFFF);
        look(); adv();
        bus(32'h100, 2'b01, 32'h0);
        look(); adv();

        // Async reset with both FIFOs holding data.
        in_valid = 1; in_data = 32'h77;
        bus(32'h408, 2'b10, 32'h55);
        look(); adv();
        in_data = 32'h78;
        bus(32'h500, 2'b00, 32'h0);
        look(); adv();
        in_valid = 0;
        rst = 1;
        #1;
        chk("arst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("arst_in_ready", {31'b0, in_ready}, 32'h0);
        m_in.delete();
        m_out.delete();
        @(negedge clk);
        rst = 0;
        #1;
        chk("arst_rel_in_ready", {31'b0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        bus(32'h40C, 2'b01, 32'h0);
        look();
        chk("arst_stat", d_bus_1[31:0], 32'h0);
        adv();
        bus(32'h010, 2'b01, 32'h0);
        look();
        chk("arst_ram", d_bus_1[31:0], 32'hDEADBEEF);
        adv();

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 7))
                0, 1:    a_bus = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
                2:       a_bus = 32'h400;
                3, 4:    a_bus = 32'h404;
                5:       a_bus = 32'h408;
                6:       a_bus = 32'h40C;
                default: a_bus = 32'h400 + $urandom_range(1, 32'h3FF);
            endcase
            c_bus     = 2'($urandom_range(0, 3));
            d_bus_2   = $urandom;
            in_data   = $urandom;
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            look(); adv();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
